// File: rtl/board_keeper.sv
// board_keeper: owns the 3x3 rolling board, accepts (location, mark) moves, reports the winner.
// Build option OLDEST_HINT_EN: drive oldestX/oldestO with the cell each player loses next.
module board_keeper #(
   parameter int MAX_PIECES = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] location,
   input  logic [1:0] mark,
   output logic [1:0] a0,
   output logic [1:0] a1,
   output logic [1:0] a2,
   output logic [1:0] a3,
   output logic [1:0] a4,
   output logic [1:0] a5,
   output logic [1:0] a6,
   output logic [1:0] a7,
   output logic [1:0] a8,
   output logic [1:0] gameend,
   output logic [3:0] oldestX,
   output logic [3:0] oldestO
);

   typedef enum logic [1:0] {PLAY = 2'd0, CHECK = 2'd1, END = 2'd2} state_t;

   localparam logic [2:0]       FULL     = 3'(MAX_PIECES);
   localparam logic [1:0]       LAST_PTR = 2'(MAX_PIECES - 1);
   localparam logic [7:0][11:0] LINES    = {12'h012, 12'h345, 12'h678, 12'h036,
                                            12'h147, 12'h258, 12'h048, 12'h246};

   state_t                         state, state_n;
   logic [8:0][1:0]                board, board_n;
   logic [1:0][MAX_PIECES-1:0][3:0] ent, ent_n;
   logic [1:0][1:0]                head, head_n, tail, tail_n;
   logic [1:0][2:0]                cnt, cnt_n;
   logic [1:0]                     gameend_n;
   logic [3:0]                     last_loc;
   logic [1:0]                     last_mark;
   logic                           accept;
   logic                           side;
   logic                           vld_p0;
   logic [3:0]                     loc_p0;
   logic [1:0]                     mark_p0;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
   endfunction

   // Both-winner case cannot happen legally; if seen, credit the mover.
   function automatic logic [1:0] judge(input logic [8:0][1:0] b, input logic [1:0] mover);
      logic       x_win;
      logic       o_win;
      logic [1:0] c0, c1, c2;
      x_win = 1'b0;
      o_win = 1'b0;
      for (int k = 0; k < 8; k++) begin
         c0 = b[LINES[k][11:8]];
         c1 = b[LINES[k][7:4]];
         c2 = b[LINES[k][3:0]];
         if (c0 == 2'b10 && c1 == 2'b10 && c2 == 2'b10) x_win = 1'b1;
         if (c0 == 2'b01 && c1 == 2'b01 && c2 == 2'b01) o_win = 1'b1;
      end
      if (x_win && o_win) return mover;
      else if (x_win)     return 2'b10;
      else if (o_win)     return 2'b01;
      else                return 2'b00;
   endfunction

   // The input block holds its last move, so a repeat of the last pair is not a new move.
   always_comb begin
      accept = 1'b0;
      if (state == PLAY && (mark == 2'b10 || mark == 2'b01) && location <= 4'd8 &&
          board[location] == 2'b00 && !(location == last_loc && mark == last_mark))
         accept = 1'b1;
   end

   assign side = mark_p0[0];

   always_comb begin
      state_n   = state;
      board_n   = board;
      ent_n     = ent;
      head_n    = head;
      tail_n    = tail;
      cnt_n     = cnt;
      gameend_n = gameend;
      case (state)
         PLAY: if (accept) state_n = CHECK;
         CHECK: begin
            if (vld_p0) begin
               // write stage: place the mark, push it, and drop the oldest when already full
               board_n[loc_p0]             = mark_p0;
               ent_n[side][tail[side]]     = loc_p0;
               tail_n[side]                = ptr_inc(tail[side]);
               if (cnt[side] == FULL) begin
                  board_n[ent[side][head[side]]] = 2'b00;
                  head_n[side]                   = ptr_inc(head[side]);
               end else begin
                  cnt_n[side] = cnt[side] + 3'd1;
               end
            end else begin
               // judge stage: board already reflects the elimination
               gameend_n = judge(board, mark_p0);
               state_n   = (gameend_n != 2'b00) ? END : PLAY;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= PLAY;
      else      state <= state_n;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         board     <= '0;
         head      <= '0;
         tail      <= '0;
         cnt       <= '0;
         gameend   <= 2'b00;
         last_loc  <= 4'd9;
         last_mark <= 2'b00;
         vld_p0    <= 1'b0;
      end else begin
         board   <= board_n;
         head    <= head_n;
         tail    <= tail_n;
         cnt     <= cnt_n;
         gameend <= gameend_n;
         vld_p0  <= accept;
         if (state == CHECK && vld_p0) begin
            last_loc  <= loc_p0;
            last_mark <= mark_p0;
         end
      end
   end

   always_ff @(posedge clk) begin
      ent <= ent_n;
      if (accept) begin
         loc_p0  <= location;
         mark_p0 <= mark;
      end
   end

`ifdef OLDEST_HINT_EN
   logic [1:0][3:0] oldest;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         oldest <= {4'd9, 4'd9};
      end else begin
         for (int p = 0; p < 2; p++)
            oldest[p] <= (cnt_n[p] == FULL) ? ent_n[p][head_n[p]] : 4'd9;
      end
   end

   assign oldestX = oldest[0];
   assign oldestO = oldest[1];
`else
   assign oldestX = 4'd9;
   assign oldestO = 4'd9;
`endif

   assign a0 = board[0];
   assign a1 = board[1];
   assign a2 = board[2];
   assign a3 = board[3];
   assign a4 = board[4];
   assign a5 = board[5];
   assign a6 = board[6];
   assign a7 = board[7];
   assign a8 = board[8];

endmodule

// File: tb/tb_board_keeper.sv
// Directed bench for board_keeper: table of held moves with expected board, plus latency/hold/reset sequences.
module tb_board_keeper;

   localparam logic [1:0] MX = 2'b10;
   localparam logic [1:0] MO = 2'b01;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] location;
   logic [1:0] mark;
   logic [1:0] a0, a1, a2, a3, a4, a5, a6, a7, a8;
   logic [1:0] gameend;
   logic [3:0] oldestX, oldestO;

   int errors = 0;
   int checks = 0;

   board_keeper #(.MAX_PIECES(3)) dut (
      .clk(clk), .rst(rst), .location(location), .mark(mark),
      .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7), .a8(a8),
      .gameend(gameend), .oldestX(oldestX), .oldestO(oldestO)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      bit         rst_first;
      logic [3:0] loc;
      logic [1:0] mk;
      string      brd;
      logic [1:0] ge;
      logic [3:0] ox;
      logic [3:0] oo;
   } vec_t;

   vec_t vecs[$];

   function automatic string cell_ch(input logic [1:0] c);
      case (c)
         2'b00:   return ".";
         2'b10:   return "X";
         2'b01:   return "O";
         default: return "?";
      endcase
   endfunction

   function automatic string board_str();
      return {cell_ch(a0), cell_ch(a1), cell_ch(a2), cell_ch(a3), cell_ch(a4),
              cell_ch(a5), cell_ch(a6), cell_ch(a7), cell_ch(a8)};
   endfunction

   function automatic logic [3:0] hint(input logic [3:0] v);
`ifdef OLDEST_HINT_EN
      return v;
`else
      return 4'd9;
`endif
   endfunction

   task automatic chk_board(input string name, input string exp);
      string got;
      got = board_str();
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: board got=%s expected=%s", name, got, exp);
      end
   endtask

   task automatic chk_val(input string name, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
      end
   endtask

   task automatic check_all(input string name, input string brd, input logic [1:0] ge,
                            input logic [3:0] ox, input logic [3:0] oo);
      chk_board({name, "_board"}, brd);
      chk_val({name, "_gameend"}, {2'b00, gameend}, {2'b00, ge});
      chk_val({name, "_oldestX"}, oldestX, hint(ox));
      chk_val({name, "_oldestO"}, oldestO, hint(oo));
   endtask

   task automatic add(input string n, input bit r, input logic [3:0] l, input logic [1:0] m,
                      input string b, input logic [1:0] g, input logic [3:0] x, input logic [3:0] o);
      vec_t v;
      v.name = n; v.rst_first = r; v.loc = l; v.mk = m;
      v.brd = b; v.ge = g; v.ox = x; v.oo = o;
      vecs.push_back(v);
   endtask

   task automatic do_reset();
      rst      = 1'b0;
      location = 4'd9;
      mark     = 2'b00;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic do_move(input logic [3:0] l, input logic [1:0] m, input int n);
      location = l;
      mark     = m;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst      = 1'b0;
      location = 4'd9;
      mark     = 2'b00;

      // game 1: basic placement and ignored moves
      add("g1_x4",     1, 4'd4, MX,    "....X....", 2'b00, 4'd9, 4'd9);
      add("g1_o0",     0, 4'd0, MO,    "O...X....", 2'b00, 4'd9, 4'd9);
      add("g1_o4occ",  0, 4'd4, MO,    "O...X....", 2'b00, 4'd9, 4'd9);
      add("g1_loc9",   0, 4'd9, MX,    "O...X....", 2'b00, 4'd9, 4'd9);
      add("g1_mark11", 0, 4'd2, 2'b11, "O...X....", 2'b00, 4'd9, 4'd9);
      add("g1_x8",     0, 4'd8, MX,    "O...X...X", 2'b00, 4'd9, 4'd9);
      // game 3: rolling elimination for both players, ending in an O row
      add("g3_x0",     1, 4'd0, MX,    "X........", 2'b00, 4'd9, 4'd9);
      add("g3_o5",     0, 4'd5, MO,    "X....O...", 2'b00, 4'd9, 4'd9);
      add("g3_x1",     0, 4'd1, MX,    "XX...O...", 2'b00, 4'd9, 4'd9);
      add("g3_o7",     0, 4'd7, MO,    "XX...O.O.", 2'b00, 4'd9, 4'd9);
      add("g3_x3",     0, 4'd3, MX,    "XX.X.O.O.", 2'b00, 4'd0, 4'd9);
      add("g3_o8",     0, 4'd8, MO,    "XX.X.O.OO", 2'b00, 4'd0, 4'd5);
      add("g3_x6",     0, 4'd6, MX,    ".X.X.OXOO", 2'b00, 4'd1, 4'd5);
      add("g3_o2",     0, 4'd2, MO,    ".XOX..XOO", 2'b00, 4'd1, 4'd7);
      add("g3_x4",     0, 4'd4, MX,    "..OXX.XOO", 2'b00, 4'd3, 4'd7);
      add("g3_o0",     0, 4'd0, MO,    "O.OXX.X.O", 2'b00, 4'd3, 4'd8);
      add("g3_x5",     0, 4'd5, MX,    "O.O.XXX.O", 2'b00, 4'd6, 4'd8);
      add("g3_o1",     0, 4'd1, MO,    "OOO.XXX..", 2'b01, 4'd6, 4'd2);
      add("g3_end_x7", 0, 4'd7, MX,    "OOO.XXX..", 2'b01, 4'd6, 4'd2);

      do_reset();
      check_all("reset", ".........", 2'b00, 4'd9, 4'd9);

      foreach (vecs[i]) begin
         if (vecs[i].rst_first) do_reset();
         do_move(vecs[i].loc, vecs[i].mk, 3);
         check_all(vecs[i].name, vecs[i].brd, vecs[i].ge, vecs[i].ox, vecs[i].oo);
      end

      // X row win: board 1 cycle after accept, gameend exactly 2
      do_reset();
      do_move(4'd0, MX, 3);
      do_move(4'd3, MO, 3);
      do_move(4'd1, MX, 3);
      do_move(4'd4, MO, 3);
      check_all("win_pre", "XX.OO....", 2'b00, 4'd9, 4'd9);
      do_move(4'd2, MX, 1);
      check_all("win_t0", "XX.OO....", 2'b00, 4'd9, 4'd9);
      @(posedge clk); #1;
      check_all("win_t1", "XXXOO....", 2'b00, 4'd0, 4'd9);
      @(posedge clk); #1;
      check_all("win_t2", "XXXOO....", 2'b10, 4'd0, 4'd9);
      do_move(4'd8, MO, 4);
      check_all("win_end_o8", "XXXOO....", 2'b10, 4'd0, 4'd9);

      // held move: one write, one push
      do_reset();
      do_move(4'd4, MX, 12);
      check_all("hold_x4", "....X....", 2'b00, 4'd9, 4'd9);
      do_move(4'd0, MX, 3);
      do_move(4'd1, MX, 3);
      check_all("hold_x01", "XX..X....", 2'b00, 4'd4, 4'd9);
      do_move(4'd2, MX, 3);
      check_all("hold_x2", "XXX......", 2'b10, 4'd0, 4'd9);

      // asynchronous reset while in CHECK, then a normal move
      do_reset();
      do_move(4'd4, MX, 2);
      chk_board("rc_pre_board", "....X....");
      rst = 1'b0;
      #2;
      check_all("rc_async", ".........", 2'b00, 4'd9, 4'd9);
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_all("rc_after", "....X....", 2'b00, 4'd9, 4'd9);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
